// File: rtl/bus_packet_framer.sv
`default_nettype none
// ============================================================================
// Module   : bus_packet_framer
// Brief    : Buffers payload beats in a small FIFO and emits framed packets
//            (header, 1..MAX_LEN data beats, trailer) on a registered bus.
// Revision : 1.0
// ============================================================================
module bus_packet_framer #(
    parameter int                   BUS_SIZE   = 16,
    parameter int                   WORD_SIZE  = 4,
    parameter int                   WORD_NUM   = BUS_SIZE / WORD_SIZE,
    parameter int                   FIFO_DEPTH = 4,
    parameter int                   MAX_LEN    = 12,
    parameter logic [WORD_SIZE-1:0] HDR_TOKEN  = 4'hF,
    parameter logic [WORD_SIZE-1:0] TRL_TOKEN  = 4'hE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE-1:0]  din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] pkt_len,
    output logic [BUS_SIZE-1:0]  data_bus,
    output logic                 bus_valid,
    output logic                 busy,
    output logic                 len_err
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = BUS_SIZE - WORD_SIZE;

    localparam logic [c_aw:0]          c_depth    = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]          c_cnt_one  = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0]        c_ptr_one  = c_aw'(1);
    localparam logic [WORD_SIZE-1:0]   c_word_one = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0]   c_max_len  = WORD_SIZE'(MAX_LEN);

    // State names describe the beat currently presented on data_bus.
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_header  = 2'd1;
    localparam logic [1:0] c_st_data    = 2'd2;
    localparam logic [1:0] c_st_trailer = 2'd3;

    logic [1:0]           r_state;
    logic [BUS_SIZE-1:0]  r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_aw:0]        r_count;
    logic [WORD_SIZE-1:0] r_remain;
    logic [WORD_SIZE-1:0] r_seq;
    logic [c_cw-1:0]      r_csum;
    logic [BUS_SIZE-1:0]  r_data_bus;
    logic                 r_bus_valid;
    logic                 r_len_err;

    logic [1:0]           w_state_nxt;
    logic [BUS_SIZE-1:0]  w_bus_nxt;
    logic                 w_valid_nxt;
    logic                 w_len_err_nxt;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_accept;
    logic [BUS_SIZE-1:0]  w_head;
    logic [BUS_SIZE-1:0]  w_hdr;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign din_ready = !w_full && !reset;
    assign w_push    = din_valid && din_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_accept  = (r_state == c_st_idle) && start &&
                       (pkt_len != '0) && (pkt_len <= c_max_len);

    assign data_bus  = r_data_bus;
    assign bus_valid = r_bus_valid;
    assign busy      = (r_state != c_st_idle);
    assign len_err   = r_len_err;

    always_comb begin
        w_hdr = '0;
        w_hdr[WORD_NUM*WORD_SIZE-1 -: WORD_SIZE] = HDR_TOKEN;
        w_hdr[2*WORD_SIZE-1 -: WORD_SIZE]        = r_seq;
        w_hdr[WORD_SIZE-1:0]                     = pkt_len;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bus_nxt     = '0;
        w_valid_nxt   = 1'b0;
        w_len_err_nxt = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_header;
                    w_bus_nxt   = w_hdr;
                    w_valid_nxt = 1'b1;
                end else if (start) begin
                    w_len_err_nxt = 1'b1;
                end
            end
            c_st_header, c_st_data: begin
                // r_remain reaches zero only once the final data beat is on the bus.
                w_state_nxt = c_st_data;
                if (r_remain == '0) begin
                    w_state_nxt = c_st_trailer;
                    w_bus_nxt   = {TRL_TOKEN, r_csum};
                    w_valid_nxt = 1'b1;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_bus_nxt   = w_head;
                    w_valid_nxt = 1'b1;
                end
            end
            c_st_trailer: w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remain    <= '0;
            r_seq       <= '0;
            r_csum      <= '0;
            r_data_bus  <= '0;
            r_bus_valid <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data_bus  <= w_bus_nxt;
            r_bus_valid <= w_valid_nxt;
            r_len_err   <= w_len_err_nxt;
            if (w_accept) begin
                r_remain <= pkt_len;
                r_csum   <= '0;
            end
            if (w_pop) begin
                r_remain <= r_remain - c_word_one;
                r_csum   <= r_csum ^ w_head[c_cw-1:0];
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (r_state == c_st_trailer) begin
                r_seq <= r_seq + c_word_one;
            end
        end
    end

    // Storage needs no reset; pushes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_packet_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_packet_framer
// Brief    : Scoreboard bench for bus_packet_framer; expected beats are queued
//            when a packet is requested and compared as the bus produces them.
// Revision : 1.0
// ============================================================================
module tb_bus_packet_framer;

    typedef struct {
        logic [15:0] d;
        int          kind;   // 0 header, 1 data, 2 trailer
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        start = 1'b0;
    logic [3:0]  pkt_len = '0;
    logic [15:0] data_bus;
    logic        bus_valid;
    logic        busy;
    logic        len_err;

    exp_t        sb[$];
    exp_t        mon_e;
    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          hdr_cyc = 0;
    int          trl_cyc = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  seq_m = '0;
    logic [15:0] pay [16];

    always #5 clk = ~clk;

    bus_packet_framer dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .start     (start),
        .pkt_len   (pkt_len),
        .data_bus  (data_bus),
        .bus_valid (bus_valid),
        .busy      (busy),
        .len_err   (len_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("no_beat_expected", 32'(bus_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("bus_beat", 32'(data_bus), 32'(mon_e.d));
                    if (mon_e.kind == 0) hdr_cyc = cyc;
                    if (mon_e.kind == 2) trl_cyc = cyc;
                end
            end else begin
                check("idle_bus_zero", {15'd0, data_bus, bus_valid}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [15:0] d);
        int n;
        n = 0;
        din = d;
        din_valid = 1'b1;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("push_timeout", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic expect_pkt(input int len);
        logic [15:0] x;
        exp_t        e;
        x = '0;
        e.d = {4'hF, 4'h0, seq_m, 4'(len)};
        e.kind = 0;
        sb.push_back(e);
        for (int i = 0; i < len; i++) begin
            e.d = pay[i];
            e.kind = 1;
            sb.push_back(e);
            x = x ^ pay[i];
        end
        e.d = {4'hE, x[11:0]};
        e.kind = 2;
        sb.push_back(e);
        seq_m = seq_m + 4'd1;
    endtask

    task automatic do_start(input logic [3:0] len);
        start = 1'b1;
        pkt_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("done_timeout", 32'(busy) | 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_bus", 32'(data_bus), 32'd0);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(din_ready), 32'd1);

        // 1: prefilled FIFO, len=2, contiguous frame
        push_beat(16'h1234);
        push_beat(16'h00FF);
        pay[0] = 16'h1234;
        pay[1] = 16'h00FF;
        expect_pkt(2);
        do_start(4'd2);
        check("t1_no_len_err", 32'(len_err), 32'd0);
        wait_done();
        check("t1_contig", 32'(trl_cyc - hdr_cyc), 32'd3);
        check("t1_gap", {15'd0, data_bus, bus_valid}, 32'd0);

        // 2: empty FIFO -> bubbles while busy
        pay[0] = 16'hAAAA;
        pay[1] = 16'h5555;
        pay[2] = 16'h0F0F;
        expect_pkt(3);
        do_start(4'd3);
        tick();
        tick();
        tick();
        check("t2_busy_held", 32'(busy), 32'd1);
        check("t2_bubble", 32'(bus_valid), 32'd0);
        push_beat(pay[0]);
        push_beat(pay[1]);
        push_beat(pay[2]);
        wait_done();
        check("t2_stretched", 32'(trl_cyc - hdr_cyc > 4), 32'd1);

        // 3: rejected lengths
        do_start(4'd0);
        check("t3_len0_err", 32'(len_err), 32'd1);
        check("t3_len0_busy", 32'(busy), 32'd0);
        tick();
        check("t3_len0_pulse", 32'(len_err), 32'd0);
        do_start(4'd13);
        check("t3_len13_err", 32'(len_err), 32'd1);
        check("t3_len13_busy", 32'(busy), 32'd0);
        tick();
        check("t3_len13_pulse", 32'(len_err), 32'd0);

        // Maximum length through a 4-deep FIFO
        for (int i = 0; i < 12; i++) pay[i] = 16'(32'h0100 * i + 32'h0013 * (i + 1));
        expect_pkt(12);
        do_start(4'd12);
        check("max_len_accepted", 32'(len_err), 32'd0);
        for (int i = 0; i < 12; i++) push_beat(pay[i]);
        wait_done();

        // 4: FIFO full backpressure
        for (int i = 0; i < 4; i++) begin
            din = 16'(32'h1111 * (i + 1));
            din_valid = 1'b1;
            tick();
        end
        check("t4_full", 32'(din_ready), 32'd0);
        din = 16'h5555;
        tick();
        tick();
        check("t4_hold", 32'(din_ready), 32'd0);
        pay[0] = 16'h1111;
        expect_pkt(1);
        do_start(4'd1);
        n = 0;
        while (!din_ready && n < 20) begin
            tick();
            n++;
        end
        check("t4_ready_after_pop", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        wait_done();
        pay[0] = 16'h2222;
        pay[1] = 16'h3333;
        pay[2] = 16'h4444;
        pay[3] = 16'h5555;
        expect_pkt(4);
        do_start(4'd4);
        wait_done();

        // 5: reset during DATA after two beats
        push_beat(16'hA001);
        push_beat(16'hA002);
        push_beat(16'hA003);
        e.d = {4'hF, 4'h0, seq_m, 4'd4};
        e.kind = 0;
        sb.push_back(e);
        e.d = 16'hA001;
        e.kind = 1;
        sb.push_back(e);
        e.d = 16'hA002;
        sb.push_back(e);
        do_start(4'd4);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t5_bus", 32'(data_bus), 32'd0);
        check("t5_valid", 32'(bus_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready_in_rst", 32'(din_ready), 32'd0);
        check("t5_sb_drained", 32'(sb.size()), 32'd0);
        reset = 1'b0;
        #1;
        check("t5_ready", 32'(din_ready), 32'd1);
        seq_m = '0;
        pay[0] = 16'hC0DE;
        push_beat(pay[0]);
        expect_pkt(1);
        do_start(4'd1);
        wait_done();

        // 6: sequence wrap over 17 packets; starts while busy ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        seq_m = '0;
        for (int i = 0; i < 17; i++) begin
            pay[0] = 16'(32'h7000 + 32'h0101 * i);
            push_beat(pay[0]);
            expect_pkt(1);
            do_start(4'd1);
            start = 1'b1;
            pkt_len = 4'd2;
            tick();
            start = 1'b0;
            check("t6_busy_start_ignored", 32'(len_err), 32'd0);
            wait_done();
        end
        tick();
        tick();
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        check("end_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
